pc_sequencer: RTL

//  Multi-cycle control sequencer for the 8-bit-instruction core. Owns the PC that addresses the

---
 rtl/core_isa_pkg.sv | 55 +++++
 rtl/pc_next_calc.sv | 38 +++
 rtl/pc_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/core_isa_pkg.sv
// core_isa_pkg
//   Shared definitions for the 8-bit-instruction core: opcode encodings,
//   instruction format codes, the sequencer state encoding and the next-PC
//   select used between pc_sequencer and pc_next_calc. Also imported by the
//   decoder and the bench.
package core_isa_pkg;

    // Opcodes (4 bits)
    localparam logic [3:0] OP_LB   = 4'd0;
    localparam logic [3:0] OP_LHB  = 4'd1;
    localparam logic [3:0] OP_STR  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_HALT = 4'd10;
    localparam logic [3:0] OP_JMP  = 4'd11;
    localparam logic [3:0] OP_BNE  = 4'd12;
    localparam logic [3:0] OP_BEQ  = 4'd13;
    localparam logic [3:0] OP_BLT  = 4'd14;
    localparam logic [3:0] OP_BLS  = 4'd15;

    // Instruction formats
    localparam logic [1:0] FMT_C = 2'd0;
    localparam logic [1:0] FMT_I = 2'd1;
    localparam logic [1:0] FMT_M = 2'd2;
    localparam logic [1:0] FMT_X = 2'd3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        HALT  = 3'd4
    } seq_state_t;

    typedef enum logic [1:0] {
        PC_SEL_HOLD   = 2'd0,
        PC_SEL_STEP   = 2'd1,
        PC_SEL_JUMP   = 2'd2,
        PC_SEL_BRANCH = 2'd3
    } pc_sel_t;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LB) || (op == OP_LHB) || (op == OP_STR);
    endfunction

    function automatic logic is_branch_op(input logic [3:0] op);
        return (op == OP_BNE) || (op == OP_BEQ) || (op == OP_BLT) || (op == OP_BLS);
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// pc_next_calc
//   Combinational next-PC mux for the sequencer.
//   Ports:
//     sel           in   pc_sel_t  hold / step / jump / branch
//     pc            in   PC_W      current PC
//     jmp_loc       in   PC_W      latched jump/branch target
//     branch_taken  in   1         branch condition (used for PC_SEL_BRANCH)
//     pc_nxt        out  PC_W      next PC, arithmetic modulo 2^PC_W
module pc_next_calc
    import core_isa_pkg::*;
#(
    parameter int              PC_W    = 16,
    parameter logic [PC_W-1:0] PC_STEP = 1
) (
    input  pc_sel_t         sel,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] jmp_loc,
    input  logic            branch_taken,
    output logic [PC_W-1:0] pc_nxt
);

    logic [PC_W-1:0] pc_step;

    // Result width equals PC_W, so 'hFFFF + 1 wraps to 0 silently.
    assign pc_step = pc + PC_STEP;

    always_comb begin
        pc_nxt = pc;
        case (sel)
            PC_SEL_HOLD:   pc_nxt = pc;
            PC_SEL_STEP:   pc_nxt = pc_step;
            PC_SEL_JUMP:   pc_nxt = jmp_loc;
            PC_SEL_BRANCH: pc_nxt = branch_taken ? jmp_loc : pc_step;
            default:       pc_nxt = pc;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Multi-cycle control sequencer: owns the instruction-ROM PC and steps
//   FETCH / EXEC / MEM per instruction, resolving jumps, branches and halt.
//   Optional retired-instruction counter enabled by defining PC_SEQ_PERF_CNT_EN;
//   without it instr_count is tied to zero.
//   Ports:
//     clk, rst_n            clock, async active-low reset
//     start                 1-cycle start pulse (honoured in IDLE or HALT)
//     abort                 synchronous return to IDLE, overrides everything
//     opcode, format,
//     jmp_loc               decoded instruction fields, latched in FETCH
//     branch_taken          ALU compare result, sampled in EXEC
//     mem_ready             data memory access complete
//     pc                    instruction ROM address
//     fetch_en, exec_en     per-phase strobes
//     mem_req, mem_we       data memory request / write qualifier
//     busy, done            activity / halted status
//     instr_count           retired instruction count
module pc_sequencer
    import core_isa_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] START_PC = '0,
    parameter logic [PC_W-1:0] PC_STEP  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [3:0]      opcode,
    input  logic [1:0]      format,
    input  logic [PC_W-1:0] jmp_loc,
    input  logic            branch_taken,
    input  logic            mem_ready,
    output logic [PC_W-1:0] pc,
    output logic            fetch_en,
    output logic            exec_en,
    output logic            mem_req,
    output logic            mem_we,
    output logic            busy,
    output logic            done,
    output logic [31:0]     instr_count
);

    seq_state_t      state, state_nxt;
    pc_sel_t         pc_sel;
    logic [PC_W-1:0] pc_calc;
    logic [PC_W-1:0] pc_nxt;
    logic [3:0]      opcode_q;
    logic [PC_W-1:0] jmp_loc_q;
    logic            load_start;
    logic            retire;
    logic            clr_cnt;

    // Sequencing depends only on the opcode; the format field is consumed by
    // the datapath decoder, not here.
    logic            format_unused;
    assign format_unused = ^format;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= START_PC;
            opcode_q  <= '0;
            jmp_loc_q <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (state == FETCH) begin
                opcode_q  <= opcode;
                jmp_loc_q <= jmp_loc;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_sel     = PC_SEL_HOLD;
        load_start = 1'b0;
        retire     = 1'b0;
        clr_cnt    = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;

        case (state)
            IDLE, HALT: begin
                if (start) begin
                    load_start = 1'b1;
                    clr_cnt    = 1'b1;
                    state_nxt  = FETCH;
                end
            end
            FETCH: state_nxt = EXEC;
            EXEC: begin
                if (opcode_q == OP_HALT) begin
                    state_nxt = HALT;
                    retire    = 1'b1;
                end else if (opcode_q == OP_JMP) begin
                    pc_sel    = PC_SEL_JUMP;
                    state_nxt = FETCH;
                    retire    = 1'b1;
                end else if (is_branch_op(opcode_q)) begin
                    pc_sel    = PC_SEL_BRANCH;
                    state_nxt = FETCH;
                    retire    = 1'b1;
                end else if (is_mem_op(opcode_q)) begin
                    mem_req = 1'b1;
                    mem_we  = (opcode_q == OP_STR);
                    // Zero-wait memory completes without visiting MEM.
                    if (mem_ready) begin
                        pc_sel    = PC_SEL_STEP;
                        state_nxt = FETCH;
                        retire    = 1'b1;
                    end else begin
                        state_nxt = MEM;
                    end
                end else begin
                    pc_sel    = PC_SEL_STEP;
                    state_nxt = FETCH;
                    retire    = 1'b1;
                end
            end
            MEM: begin
                mem_req = 1'b1;
                mem_we  = (opcode_q == OP_STR);
                if (mem_ready) begin
                    pc_sel    = PC_SEL_STEP;
                    state_nxt = FETCH;
                    retire    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Abort overrides any transition this cycle, including a concurrent
        // start; the instruction in flight does not retire.
        if (abort) begin
            state_nxt  = IDLE;
            pc_sel     = PC_SEL_HOLD;
            load_start = 1'b1;
            retire     = 1'b0;
            clr_cnt    = 1'b0;
        end
    end

    pc_next_calc #(
        .PC_W    (PC_W),
        .PC_STEP (PC_STEP)
    ) u_pc_next_calc (
        .sel          (pc_sel),
        .pc           (pc),
        .jmp_loc      (jmp_loc_q),
        .branch_taken (branch_taken),
        .pc_nxt       (pc_calc)
    );

    assign pc_nxt   = load_start ? START_PC : pc_calc;
    assign fetch_en = (state == FETCH);
    assign exec_en  = (state == EXEC);
    assign busy     = (state == FETCH) || (state == EXEC) || (state == MEM);
    assign done     = (state == HALT);

`ifdef PC_SEQ_PERF_CNT_EN
    logic [31:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr_cnt) begin
            cnt <= '0;
        end else if (retire && (cnt != 32'hFFFF_FFFF)) begin
            cnt <= cnt + 32'd1;
        end
    end

    assign instr_count = cnt;
`else
    logic cnt_unused;
    assign cnt_unused  = retire ^ clr_cnt;
    assign instr_count = 32'd0;
`endif

endmodule
